fpu_unpack_stage: RTL and testbench
===================================

FPU_UNPACK_STAGE -- requirements
Module: fpu_unpack_stage

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored fraction width; operand width = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
REQ-007 SHALL have ports in_a, in_b  input  32  IEEE-754 single operands.
REQ-008 SHALL have port in_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-009 SHALL have port out_valid  output  1  unpacked pair valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-011 SHALL have ports out_a, out_b  output  36  {class[2:0], sign, exp[7:0], man[23:0]} (man includes hidden bit).
REQ-012 SHALL have port out_op  output  2  in_op passed through.

Function
REQ-013 SHALL classify each operand: exp=0,frac=0 ZERO(0); exp=0,frac!=0 SUBN(1); exp 1..254 NORM(2); exp=255,frac=0 INF(3); exp=255,frac[22]=1 QNAN(4); exp=255,frac[22]=0,frac!=0 SNAN(5).
REQ-014 SHALL unpack NORM: man={1,frac}, exp=field; INF/NaN: man={0,frac}, exp=255; ZERO: man=0, exp=0; sign always preserved.
REQ-015 SHALL, for in_op=SUB, invert sign of b unless b class is QNAN or SNAN.
REQ-016 SHALL have latency 1: pair accepted at edge N is presented with out_valid=1 after edge N; throughput 1 pair/cycle with out_ready=1.
REQ-017 SHALL implement a 2-entry skid buffer, FSM states EMPTY, ONE, TWO.
REQ-018 SHALL transition EMPTY->ONE on input transfer; ONE->TWO on input transfer without output transfer; ONE->EMPTY on output transfer without input; TWO->ONE on output transfer; otherwise hold.
REQ-019 SHALL drive in_ready=1 in EMPTY and ONE, 0 in TWO, from registered state only (no combinational out_ready->in_ready path).
REQ-020 SHALL hold out_a/out_b/out_op stable while out_valid=1 and out_ready=0.
REQ-021 SHALL preserve strict FIFO order; no pair dropped or duplicated.
REQ-022 SHALL ignore in_a/in_b/in_op when no input transfer occurs.

Reset
REQ-023 SHALL, while rst=1, force state EMPTY, out_valid=0, in_ready=1, out_a=out_b=0, out_op=0, skid contents 0.
REQ-024 SHALL, on rst mid-operation, discard all buffered pairs; first post-reset acceptance behaves as from EMPTY.

Configuration
REQ-025 SHALL with FPU_DENORM_EN defined unpack SUBN as class SUBN, exp=1, man={0,frac}.
REQ-026 SHALL without FPU_DENORM_EN flush SUBN to class ZERO, exp=0, man=0, sign preserved.

Structure
REQ-027 SHALL take class encodings, op encodings, EXP_W/MAN_W defaults and unpacked-field widths from package fpu_pkg.
REQ-028 SHALL instantiate combinational sub-module fpu_unpack twice (one per operand); buffer registers use the existing enabled register block.

Verification
REQ-029 SHALL cover: ADD, a=0x3F800000, b=0xC0000000 -> next cycle out_a={2,0,0x7F,0x800000}, out_b={2,1,0x80,0x800000}.
REQ-030 SHALL cover: SUB, b=0x7FC00000 -> out_b class 4, sign 0 (not inverted); SUB, b=0x40000000 -> out_b sign 1.
REQ-031 SHALL cover: a=0x00000001 -> with FPU_DENORM_EN {1,0,0x01,0x000001}; without {0,0,0x00,0}; b=0x7F800001 -> class 5.
REQ-032 SHALL cover: out_ready=0, three back-to-back pairs P0..P2 -> P0,P1 accepted, in_ready=0 after second; out_ready=1 -> P0,P1,P2 out in order, one per cycle.
REQ-033 SHALL cover: state TWO, assert rst one cycle -> out_valid=0, in_ready=1 immediately; no stale pair emerges after release.
REQ-034 SHALL cover: continuous in_valid=out_ready=1 for 100 random pairs -> 100 outputs, latency 1, matching reference model.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared encodings and default widths for the FPU unpack stage.
package fpu_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int CLS_W     = 3;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUBN = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } fp_class_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } fp_op_e;

  // Unpacked operand: {class, sign, exp, man incl. hidden bit}
  function automatic int unp_width(input int exp_w, input int man_w);
    return CLS_W + 1 + exp_w + man_w + 1;
  endfunction

endpackage

// File: rtl/fpu_en_reg.sv
// Enabled register with asynchronous active-high clear.
module fpu_en_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] data_d,
  output logic [W-1:0] data_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/fpu_unpack.sv
// Combinational IEEE-754 operand classifier/unpacker.
// FPU_DENORM_EN keeps subnormals; otherwise they are flushed to signed zero.
module fpu_unpack
  import fpu_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic [EXP_W+MAN_W:0]           opnd,
  input  logic                           neg_req,
  output logic [CLS_W+EXP_W+MAN_W+1:0]   unp
);

  logic             sign_in;
  logic [EXP_W-1:0] exp_in;
  logic [MAN_W-1:0] frac_in;
  logic             exp_zero;
  logic             exp_max;
  logic             frac_zero;
  fp_class_e        cls;
  logic             sign_out;
  logic [EXP_W-1:0] exp_out;
  logic [MAN_W:0]   man_out;

  assign sign_in   = opnd[EXP_W+MAN_W];
  assign exp_in    = opnd[EXP_W+MAN_W-1:MAN_W];
  assign frac_in   = opnd[MAN_W-1:0];
  assign exp_zero  = ~|exp_in;
  assign exp_max   = &exp_in;
  assign frac_zero = ~|frac_in;

  always_comb begin
    cls     = CLS_NORM;
    exp_out = exp_in;
    man_out = {1'b1, frac_in};
    if (exp_zero) begin
      if (frac_zero) begin
        cls     = CLS_ZERO;
        exp_out = '0;
        man_out = '0;
      end else begin
`ifdef FPU_DENORM_EN
        // Subnormals share the minimum normal exponent, without the hidden bit
        cls     = CLS_SUBN;
        exp_out = EXP_W'(1);
        man_out = {1'b0, frac_in};
`else
        cls     = CLS_ZERO;
        exp_out = '0;
        man_out = '0;
`endif
      end
    end else if (exp_max) begin
      man_out = {1'b0, frac_in};
      if (frac_zero) begin
        cls = CLS_INF;
      end else if (frac_in[MAN_W-1]) begin
        cls = CLS_QNAN;
      end else begin
        cls = CLS_SNAN;
      end
    end
  end

  // NaN payload signs are left untouched by subtraction
  assign sign_out = sign_in ^ (neg_req & (cls != CLS_QNAN) & (cls != CLS_SNAN));
  assign unp      = {cls, sign_out, exp_out, man_out};

endmodule

// File: rtl/fpu_unpack_stage.sv
// Operand unpack pipeline stage with a 2-entry skid buffer (latency 1).
// FPU_DENORM_EN selects subnormal handling inside fpu_unpack.
//
// state    | meaning
// EMPTY    | no pair buffered, out_valid=0
// ONE      | head holds one pair
// TWO      | head and skid both hold pairs, in_ready=0
module fpu_unpack_stage
  import fpu_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [EXP_W+MAN_W:0]          in_a,
  input  logic [EXP_W+MAN_W:0]          in_b,
  input  logic [1:0]                    in_op,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CLS_W+EXP_W+MAN_W+1:0]  out_a,
  output logic [CLS_W+EXP_W+MAN_W+1:0]  out_b,
  output logic [1:0]                    out_op
);

  localparam int UNP_W  = unp_width(EXP_W, MAN_W);
  localparam int PAIR_W = 2 + 2 * UNP_W;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [UNP_W-1:0]  unp_a, unp_b;
  logic [PAIR_W-1:0] new_pair;
  logic [PAIR_W-1:0] head_q, head_d, skid_q;
  logic              head_en, skid_en;
  logic              in_xfer, out_xfer;

  fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .opnd    (in_a),
    .neg_req (1'b0),
    .unp     (unp_a)
  );

  fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .opnd    (in_b),
    .neg_req (in_op == OP_SUB),
    .unp     (unp_b)
  );

  assign new_pair  = {in_op, unp_a, unp_b};
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_en = 1'b0;
    skid_en = 1'b0;
    head_d  = new_pair;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          head_en = 1'b1;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          head_en = 1'b1;
        end else if (in_xfer) begin
          skid_en = 1'b1;
          state_d = ST_TWO;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          head_en = 1'b1;
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  fpu_en_reg #(.W(PAIR_W)) u_head_reg (
    .clk    (clk),
    .rst    (rst),
    .en     (head_en),
    .data_d (head_d),
    .data_q (head_q)
  );

  fpu_en_reg #(.W(PAIR_W)) u_skid_reg (
    .clk    (clk),
    .rst    (rst),
    .en     (skid_en),
    .data_d (new_pair),
    .data_q (skid_q)
  );

  assign out_op = head_q[PAIR_W-1 -: 2];
  assign out_a  = head_q[2*UNP_W-1 -: UNP_W];
  assign out_b  = head_q[UNP_W-1:0];

endmodule

// File: tb/tb_fpu_unpack_stage.sv
// Directed and random self-checking bench for fpu_unpack_stage.
module tb_fpu_unpack_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_a, out_b;
  logic [1:0]  out_op;

  int n_cmp = 0;
  int n_err = 0;

  fpu_unpack_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_op    (out_op)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Independent reference: decode by numeric field ranges
  function automatic logic [35:0] ref_unp(input logic [31:0] x, input logic neg);
    logic       s;
    int         e;
    int         f;
    logic [2:0] c;
    logic [7:0] eo;
    logic [23:0] mo;
    s = x[31];
    e = int'(x[30:23]);
    f = int'(x[22:0]);
    if (e == 255) begin
      eo = 8'hFF;
      mo = {1'b0, x[22:0]};
      if (f == 0) c = 3'd3;
      else if (f >= 32'h0040_0000) c = 3'd4;
      else c = 3'd5;
    end else if (e == 0) begin
      if (f == 0) begin
        c = 3'd0; eo = 8'h00; mo = 24'h0;
      end else begin
`ifdef FPU_DENORM_EN
        c = 3'd1; eo = 8'h01; mo = {1'b0, x[22:0]};
`else
        c = 3'd0; eo = 8'h00; mo = 24'h0;
`endif
      end
    end else begin
      c = 3'd2; eo = x[30:23]; mo = {1'b1, x[22:0]};
    end
    if (neg && c != 3'd4 && c != 3'd5) s = ~s;
    return {c, s, eo, mo};
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 32'h0; in_b = 32'h0; in_op = 2'd0;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_a !== 36'h0 || out_b !== 36'h0) begin n_err++; $display("FAIL rst_data: got a=%h b=%h want 0", out_a, out_b); end
    n_cmp++; if (out_op !== 2'd0) begin n_err++; $display("FAIL rst_op: got %0d want 0", out_op); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'hC000_0000; in_op = 2'd0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_op = 2'd3;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_a !== {3'd2, 1'b0, 8'h7F, 24'h800000}) begin n_err++; $display("FAIL add_a: got %h want %h", out_a, {3'd2, 1'b0, 8'h7F, 24'h800000}); end
    n_cmp++; if (out_b !== {3'd2, 1'b1, 8'h80, 24'h800000}) begin n_err++; $display("FAIL add_b: got %h want %h", out_b, {3'd2, 1'b1, 8'h80, 24'h800000}); end
    n_cmp++; if (out_op !== 2'd0) begin n_err++; $display("FAIL add_op: got %0d want 0", out_op); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_sub;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h7FC0_0000; in_op = 2'd1;
    tick;
    n_cmp++; if (out_b !== {3'd4, 1'b0, 8'hFF, 24'h400000}) begin n_err++; $display("FAIL sub_qnan_b: got %h want %h", out_b, {3'd4, 1'b0, 8'hFF, 24'h400000}); end
    n_cmp++; if (out_op !== 2'd1) begin n_err++; $display("FAIL sub_op: got %0d want 1", out_op); end
    in_b = 32'h4000_0000;
    tick;
    n_cmp++; if (out_b !== {3'd2, 1'b1, 8'h80, 24'h800000}) begin n_err++; $display("FAIL sub_norm_b: got %h want %h", out_b, {3'd2, 1'b1, 8'h80, 24'h800000}); end
    in_b = 32'h8000_0000;
    tick;
    n_cmp++; if (out_b !== {3'd0, 1'b0, 8'h00, 24'h000000}) begin n_err++; $display("FAIL sub_negzero_b: got %h want %h", out_b, 36'h0); end
    in_b = 32'hFF80_0001; in_op = 2'd1;
    tick;
    n_cmp++; if (out_b !== {3'd5, 1'b1, 8'hFF, 24'h000001}) begin n_err++; $display("FAIL sub_snan_b: got %h want %h", out_b, {3'd5, 1'b1, 8'hFF, 24'h000001}); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_class;
    logic [35:0] exp_sub_a, exp_sub_b;
`ifdef FPU_DENORM_EN
    exp_sub_a = {3'd1, 1'b0, 8'h01, 24'h000001};
    exp_sub_b = {3'd1, 1'b1, 8'h01, 24'h000005};
`else
    exp_sub_a = {3'd0, 1'b0, 8'h00, 24'h000000};
    exp_sub_b = {3'd0, 1'b1, 8'h00, 24'h000000};
`endif
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h0000_0001; in_b = 32'h7F80_0001; in_op = 2'd0;
    tick;
    n_cmp++; if (out_a !== exp_sub_a) begin n_err++; $display("FAIL cls_subn_a: got %h want %h", out_a, exp_sub_a); end
    n_cmp++; if (out_b !== {3'd5, 1'b0, 8'hFF, 24'h000001}) begin n_err++; $display("FAIL cls_snan_b: got %h want %h", out_b, {3'd5, 1'b0, 8'hFF, 24'h000001}); end
    in_a = 32'hFF80_0000; in_b = 32'h8000_0005; in_op = 2'd2;
    tick;
    n_cmp++; if (out_a !== {3'd3, 1'b1, 8'hFF, 24'h000000}) begin n_err++; $display("FAIL cls_inf_a: got %h want %h", out_a, {3'd3, 1'b1, 8'hFF, 24'h000000}); end
    n_cmp++; if (out_b !== exp_sub_b) begin n_err++; $display("FAIL cls_subn_b: got %h want %h", out_b, exp_sub_b); end
    n_cmp++; if (out_op !== 2'd2) begin n_err++; $display("FAIL cls_op: got %0d want 2", out_op); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h4000_0000; in_op = 2'd0;
    tick;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_one: got %b want 1", in_ready); end
    in_a = 32'h4040_0000; in_b = 32'h0000_0000; in_op = 2'd2;
    tick;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_two: got %b want 0", in_ready); end
    in_a = 32'hBF80_0000; in_b = 32'h3F00_0000; in_op = 2'd3;
    tick;
    n_cmp++; if (out_valid !== 1'b1 || out_a !== {3'd2, 1'b0, 8'h7F, 24'h800000} || out_op !== 2'd0)
      begin n_err++; $display("FAIL b2b_hold_p0: got v=%b a=%h op=%0d want v=1 a=%h op=0", out_valid, out_a, out_op, {3'd2, 1'b0, 8'h7F, 24'h800000}); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_hold: got %b want 0", in_ready); end
    out_ready = 1'b1;
    // P0 is taken at this edge while P2 is still blocked
    tick;
    n_cmp++; if (out_a !== {3'd2, 1'b0, 8'h80, 24'hC00000} || out_b !== 36'h0 || out_op !== 2'd2)
      begin n_err++; $display("FAIL b2b_p1: got a=%h b=%h op=%0d want a=%h b=0 op=2", out_a, out_b, out_op, {3'd2, 1'b0, 8'h80, 24'hC00000}); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_free: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_a !== {3'd2, 1'b1, 8'h7F, 24'h800000} || out_b !== {3'd2, 1'b0, 8'h7E, 24'h800000} || out_op !== 2'd3)
      begin n_err++; $display("FAIL b2b_p2: got v=%b a=%h b=%h op=%0d want v=1 a=%h b=%h op=3", out_valid, out_a, out_b, out_op, {3'd2, 1'b1, 8'h7F, 24'h800000}, {3'd2, 1'b0, 8'h7E, 24'h800000}); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'h4040_0000; in_b = 32'h3F80_0000; in_op = 2'd0;
    tick;
    in_a = 32'h4080_0000;
    tick;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_two: got in_ready=%b want 0", in_ready); end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_async: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    n_cmp++; if (out_a !== 36'h0 || out_op !== 2'd0) begin n_err++; $display("FAIL rmid_clear: got a=%h op=%0d want 0", out_a, out_op); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    tick;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale: got %b want 0", out_valid); end
    in_valid = 1'b1; in_a = 32'h3F00_0000; in_b = 32'hC040_0000; in_op = 2'd1;
    tick;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_a !== {3'd2, 1'b0, 8'h7E, 24'h800000} || out_b !== {3'd2, 1'b0, 8'h80, 24'hC00000})
      begin n_err++; $display("FAIL rmid_first: got v=%b a=%h b=%h want v=1 a=%h b=%h", out_valid, out_a, out_b, {3'd2, 1'b0, 8'h7E, 24'h800000}, {3'd2, 1'b0, 8'h80, 24'hC00000}); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_after: got %b want 0", out_valid); end
  endtask

  function automatic logic [31:0] rand_opnd();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 3))
      0: x[30:23] = 8'h00;
      1: x[30:23] = 8'hFF;
      default: ;
    endcase
    return x;
  endfunction

  task automatic test_stream;
    logic [35:0] ea, eb;
    logic [1:0]  eo;
    int          bad;
    bad = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_a = rand_opnd();
      in_b = rand_opnd();
      in_op = 2'($urandom_range(0, 3));
      ea = ref_unp(in_a, 1'b0);
      eb = ref_unp(in_b, in_op == 2'd1);
      eo = in_op;
      tick;
      n_cmp++;
      if (out_valid !== 1'b1 || out_a !== ea || out_b !== eb || out_op !== eo) begin
        n_err++;
        bad++;
        if (bad <= 5)
          $display("FAIL stream[%0d]: got v=%b a=%h b=%h op=%0d want v=1 a=%h b=%h op=%0d",
                   i, out_valid, out_a, out_b, out_op, ea, eb, eo);
      end
    end
    in_valid = 1'b0;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_class;
    test_back_to_back;
    test_reset_mid;
    test_stream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
